multi_dataflow_out_tiler: RTL and testbench

Output-side tiling stage placed directly downstream of the multi-dataflow kernel adapter's output stream and upstream of the HWPE source streamer. It buffers kernel output beats in a small FIFO and counts them against a per-tile length programmed by the engine FSM. When the tile is complete it stops accepting beats, drains the FIFO, and emits a one-cycle tile-done pulse that the controller uses to advance addresses.

---
 rtl/multi_dataflow_out_tiler_pkg.sv | 34 +++
 rtl/multi_dataflow_out_tiler_if.sv | 23 ++
 rtl/multi_dataflow_out_tiler_fifo.sv | 67 ++++++
 rtl/multi_dataflow_out_tiler.sv | 117 +++++++++++
 tb/tb_multi_dataflow_out_tiler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/multi_dataflow_out_tiler_pkg.sv
// ============================================================================
// multi_dataflow_package : shared types for the output tiler
// Revision: 1.0
// ============================================================================
`default_nettype none

package multi_dataflow_package;

    localparam int unsigned OUT_TILER_STALL_W = 32;
    localparam int unsigned OUT_TILER_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } out_tiler_state_t;

    typedef struct packed {
        logic                       start;
        logic [OUT_TILER_CNT_W-1:0] len;
    } ctrl_out_tiler_t;

    typedef struct packed {
        logic                         idle;
        logic                         busy;
        logic                         tile_done;
        logic [OUT_TILER_CNT_W-1:0]   count;
        logic [OUT_TILER_STALL_W-1:0] stall_cnt;
    } flags_out_tiler_t;

endpackage

`default_nettype wire

// File: rtl/multi_dataflow_out_tiler_if.sv
// ============================================================================
// hwpe_stream_intf_stream : valid/ready stream with data and byte strobes
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input  ready);
    modport sink   (input  valid, input  data, input  strb, output ready);
    modport master (output valid, output data, output strb, input  ready);
    modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

`default_nettype wire

// File: rtl/multi_dataflow_out_tiler_fifo.sv
// ============================================================================
// multi_dataflow_out_tiler_fifo : registered FIFO, no fall-through
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_dataflow_out_tiler_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_ni,
    input  wire logic                    clear_i,
    input  wire logic                    push_i,
    input  wire logic [DATA_WIDTH-1:0]   push_data_i,
    input  wire logic [DATA_WIDTH/8-1:0] push_strb_i,
    input  wire logic                    pop_i,
    output logic      [DATA_WIDTH-1:0]   pop_data_o,
    output logic      [DATA_WIDTH/8-1:0] pop_strb_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned WORD_W = DATA_WIDTH + DATA_WIDTH / 8;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (occ == OCC_W'(FIFO_DEPTH));
    assign empty_o = (occ == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= {push_strb_i, push_data_i};
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign {pop_strb_o, pop_data_o} = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/multi_dataflow_out_tiler.sv
// ============================================================================
// multi_dataflow_out_tiler : buffers kernel output beats per tile, pulses done
// Option: MULTI_DATAFLOW_OUT_TILER_STALL_CNT_EN enables the stall counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_dataflow_out_tiler
    import multi_dataflow_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        clear_i,
    hwpe_stream_intf_stream.sink   in_i,
    hwpe_stream_intf_stream.source out_o,
    input  ctrl_out_tiler_t  ctrl_i,
    output flags_out_tiler_t flags_o
);

    out_tiler_state_t               state;
    logic [CNT_WIDTH-1:0]           len_q;
    logic [CNT_WIDTH-1:0]           count;
    logic [CNT_WIDTH-1:0]           count_next;
    logic [OUT_TILER_STALL_W-1:0]   stall_cnt;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           push;
    logic                           pop;

    assign in_i.ready  = (state == RUN) & ~fifo_full;
    assign out_o.valid = ~fifo_empty;
    assign push        = in_i.valid & in_i.ready;
    assign pop         = out_o.valid & out_o.ready;
    assign count_next  = count + CNT_WIDTH'(1);

    multi_dataflow_out_tiler_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (push),
        .push_data_i (in_i.data),
        .push_strb_i (in_i.strb),
        .pop_i       (pop),
        .pop_data_o  (out_o.data),
        .pop_strb_o  (out_o.strb),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state <= IDLE;
            len_q <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_i.start) begin
                        count <= '0;
                        len_q <= CNT_WIDTH'(ctrl_i.len);
                        // A zero-length tile completes without accepting beats
                        state <= (ctrl_i.len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push) begin
                        count <= count_next;
                        if (count_next == len_q) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MULTI_DATAFLOW_OUT_TILER_STALL_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            stall_cnt <= '0;
        end else if (state == IDLE) begin
            if (ctrl_i.start) stall_cnt <= '0;
        end else if ((state == RUN || state == DRAIN) && out_o.valid && !out_o.ready
                     && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + OUT_TILER_STALL_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
`endif

    always_comb begin
        flags_o           = '0;
        flags_o.idle      = (state == IDLE);
        flags_o.busy      = (state != IDLE);
        flags_o.tile_done = (state == DONE);
        flags_o.count     = OUT_TILER_CNT_W'(count);
        flags_o.stall_cnt = stall_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_dataflow_out_tiler.sv
// ============================================================================
// tb_multi_dataflow_out_tiler : directed + randomized checks against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multi_dataflow_out_tiler;

    localparam int unsigned DEPTH = 4;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clear;
    multi_dataflow_package::ctrl_out_tiler_t  ctrl;
    multi_dataflow_package::flags_out_tiler_t flags;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) in_s ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) out_s ();

    multi_dataflow_out_tiler #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .in_i    (in_s),
        .out_o   (out_s),
        .ctrl_i  (ctrl),
        .flags_o (flags)
    );

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Reference model: tile phase, buffered beats and counters
    int          m_phase = P_IDLE;
    logic [35:0] m_q[$];
    int unsigned m_len   = 0;
    int unsigned m_count = 0;
    int unsigned m_stall = 0;
    int unsigned m_pushes = 0, m_pops = 0;
    int unsigned obs_pushes = 0, obs_pops = 0;
    logic [31:0] tx_data = 32'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rstn, input bit clr, input bit st, input int unsigned len,
                        input bit iv, input bit ordy);
        bit exp_in_ready, exp_out_valid, push, pop, was_empty;
        @(negedge clk);
        exp_in_ready  = (m_phase == P_RUN) && (m_q.size() < DEPTH);
        exp_out_valid = (m_q.size() != 0);
        check_eq("in_ready",  64'(in_s.ready),      64'(exp_in_ready));
        check_eq("out_valid", 64'(out_s.valid),     64'(exp_out_valid));
        if (exp_out_valid) begin
            check_eq("out_data", 64'(out_s.data), 64'(m_q[0][31:0]));
            check_eq("out_strb", 64'(out_s.strb), 64'(m_q[0][35:32]));
        end
        check_eq("idle",      64'(flags.idle),      64'(m_phase == P_IDLE));
        check_eq("busy",      64'(flags.busy),      64'(m_phase != P_IDLE));
        check_eq("tile_done", 64'(flags.tile_done), 64'(m_phase == P_DONE));
        check_eq("count",     64'(flags.count),     64'(m_count));
        check_eq("stall_cnt", 64'(flags.stall_cnt), 64'(m_stall));

        rst_n       = rstn;
        clear       = clr;
        ctrl.start  = st;
        ctrl.len    = 16'(len);
        in_s.valid  = iv;
        in_s.data   = tx_data;
        in_s.strb   = tx_data[3:0] ^ 4'hA;
        out_s.ready = ordy;

        push = iv && exp_in_ready;
        pop  = exp_out_valid && ordy;
        if (rstn && !clr) begin
            if (in_s.ready && iv)   obs_pushes++;
            if (out_s.valid && ordy) obs_pops++;
        end

        if (!rstn || clr) begin
            m_phase = P_IDLE;
            m_q.delete();
            m_count = 0;
            m_stall = 0;
        end else begin
`ifdef MULTI_DATAFLOW_OUT_TILER_STALL_CNT_EN
            if (m_phase == P_IDLE && st)
                m_stall = 0;
            else if ((m_phase == P_RUN || m_phase == P_DRAIN) && exp_out_valid && !ordy
                     && m_stall != 32'hFFFF_FFFF)
                m_stall++;
`endif
            was_empty = (m_q.size() == 0);
            if (pop) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            if (push) begin
                m_q.push_back({tx_data[3:0] ^ 4'hA, tx_data});
                m_pushes++;
                tx_data = tx_data + 32'd1;
            end
            case (m_phase)
                P_IDLE: if (st) begin
                    m_count = 0;
                    m_len   = len;
                    m_phase = (len == 0) ? P_DONE : P_RUN;
                end
                P_RUN: if (push) begin
                    m_count++;
                    if (m_count == m_len) m_phase = P_DRAIN;
                end
                P_DRAIN: if (was_empty) m_phase = P_DONE;
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; ctrl = '0;
        in_s.valid = 1'b0; in_s.data = '0; in_s.strb = '0; out_s.ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held while the producer offers a beat
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1);

        // len=8, continuous input, sink always ready
        tx_data = 32'd0;
        step(1, 0, 1, 8, 0, 1);
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 1, 1);

        // len=6 with sink back-pressured for 10 cycles
        step(1, 0, 1, 6, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1, 1);

        // Zero-length tile
        step(1, 0, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 1);

        // Second start during RUN is ignored
        step(1, 0, 1, 4, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 1, 9, 1, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 1);

        // Reset mid-tile with three beats buffered
        step(1, 0, 1, 8, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 1);

        // Randomized tiles, handshakes and occasional soft clears
        tx_data = $urandom;
        for (int i = 0; i < 2000; i++) begin
            bit st;
            bit clr;
            st  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 199) == 0);
            step(1, clr, st, $urandom_range(0, 12),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0, 1);

        check_eq("in_handshakes",  64'(obs_pushes), 64'(m_pushes));
        check_eq("out_handshakes", 64'(obs_pops),   64'(m_pops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
